// File: rtl/leaf_pkg.sv
// Shared types and defaults for the leaf2 lane-merge receive path.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package leaf_pkg;

  typedef enum logic {LANE0 = 1'b0, LANE1 = 1'b1} lane_e;

  typedef enum logic {RUN = 1'b0, ERR = 1'b1} merge_state_e;

  localparam int LEAF_FIFO_DEPTH_DEF = 4;
  localparam int LEAF_CNT_W_DEF      = 16;

endpackage

// File: rtl/leaf_lane_fifo.sv
// 1-bit synchronous FIFO holding one lane's bits until the merger wants them.
// Latency: a pushed bit is visible at head one edge after it is written.
// Backpressure: none upstream; pushes while full are ignored, pops while empty are ignored.
module leaf_lane_fifo
  import leaf_pkg::*;
#(
  parameter int DEPTH = LEAF_FIFO_DEPTH_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic flush,
  input  logic push,
  input  logic din,
  input  logic pop,
  output logic full,
  output logic empty,
  output logic head
);

  localparam int AW = $clog2(DEPTH);

  // Extra MSB on each pointer distinguishes full from empty when indices match.
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [DEPTH-1:0] mem;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head  = mem[rd_ptr[AW-1:0]];

  // Pointer update; full/empty are judged on pre-edge pointers, so a pop never frees room for a same-edge push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + 1'b1;
      if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset: empty pointers make stale contents unreachable.
  always_ff @(posedge clk) begin
    if (push && !full && !flush) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/leaf_merge.sv
// Recombines the two leaf2 serial lanes into one stream in strict lane0,lane1 order.
// Latency: bit pushed at edge t into the expected lane's empty FIFO appears at edge t+1.
// Backpressure: none; a push into a full lane FIFO drops the bit, sets sticky ovf_err and freezes in ERR until clr.
module leaf_merge
  import leaf_pkg::*;
#(
  parameter int DEPTH = LEAF_FIFO_DEPTH_DEF,
  parameter int CNT_W = LEAF_CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in0,
  input  logic             in0_vld,
  input  logic             in1,
  input  logic             in1_vld,
  input  logic             clr,
  output logic             out,
  output logic             out_vld,
  output logic             lane_sel,
  output logic             ovf_err,
  output logic [CNT_W-1:0] bit_cnt
);

  merge_state_e state;
  lane_e        nxt_lane;

  logic full0, empty0, head0;
  logic full1, empty1, head1;
  logic accept;
  logic push0, push1;
  logic pop0, pop1;
  logic do_pop;
  logic head_sel;
  logic ovf;

  // clr beats any same-cycle traffic; ERR freezes both FIFOs.
  assign accept   = (state == RUN) && !clr;
  assign push0    = accept && in0_vld;
  assign push1    = accept && in1_vld;
  assign ovf      = accept && ((in0_vld && full0) || (in1_vld && full1));
  assign do_pop   = accept && ((nxt_lane == LANE0) ? !empty0 : !empty1);
  assign pop0     = do_pop && (nxt_lane == LANE0);
  assign pop1     = do_pop && (nxt_lane == LANE1);
  assign head_sel = (nxt_lane == LANE0) ? head0 : head1;

  leaf_lane_fifo #(.DEPTH(DEPTH)) u_fifo0 (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (clr),
    .push  (push0),
    .din   (in0),
    .pop   (pop0),
    .full  (full0),
    .empty (empty0),
    .head  (head0)
  );

  leaf_lane_fifo #(.DEPTH(DEPTH)) u_fifo1 (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (clr),
    .push  (push1),
    .din   (in1),
    .pop   (pop1),
    .full  (full1),
    .empty (empty1),
    .head  (head1)
  );

  // Merge FSM: ordered pop, output register, delivered-bit counter and sticky overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= RUN;
      nxt_lane <= LANE0;
      out      <= 1'b0;
      out_vld  <= 1'b0;
      lane_sel <= 1'b0;
      ovf_err  <= 1'b0;
      bit_cnt  <= '0;
    end else if (clr) begin
      state    <= RUN;
      nxt_lane <= LANE0;
      out_vld  <= 1'b0;
      ovf_err  <= 1'b0;
      bit_cnt  <= '0;
    end else begin
      case (state)
        RUN: begin
          if (do_pop) begin
            out      <= head_sel;
            out_vld  <= 1'b1;
            lane_sel <= nxt_lane;
            nxt_lane <= (nxt_lane == LANE0) ? LANE1 : LANE0;
            bit_cnt  <= bit_cnt + CNT_W'(1);
          end else begin
            out_vld <= 1'b0;
          end
          if (ovf) begin
            state   <= ERR;
            ovf_err <= 1'b1;
          end
        end
        default: begin
          out_vld <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_leaf_merge.sv
// Directed bench for leaf_merge with an expected-output scoreboard.
// Latency: checks the one-cycle push-to-output path and async reset.
// Backpressure: exercises overflow, ERR freeze and clr recovery.
module tb_leaf_merge;

  localparam int DEPTH = 4;
  localparam int CNT_W = 4;

  logic             clk;
  logic             rst_n;
  logic             in0, in0_vld, in1, in1_vld, clr;
  logic             out, out_vld, lane_sel, ovf_err;
  logic [CNT_W-1:0] bit_cnt;

  int vectors;
  int miscompares;
  logic [1:0] exp_q[$];  // {lane, bit} in expected output order

  leaf_merge #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in0      (in0),
    .in0_vld  (in0_vld),
    .in1      (in1),
    .in1_vld  (in1_vld),
    .clr      (clr),
    .out      (out),
    .out_vld  (out_vld),
    .lane_sel (lane_sel),
    .ovf_err  (ovf_err),
    .bit_cnt  (bit_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Drive one cycle's inputs at the falling edge, return just after the rising edge.
  task automatic tick(input logic v0, input logic d0, input logic v1, input logic d1, input logic c);
    @(negedge clk);
    in0_vld = v0; in0 = d0; in1_vld = v1; in1 = d1; clr = c;
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every delivered bit must match the head of the expected queue.
  always @(posedge clk) begin
    #1;
    if (rst_n === 1'b1 && out_vld === 1'b1) begin
      vectors++;
      assert (exp_q.size() != 0) else begin
        miscompares++;
        $error("FAIL unexpected_out: observed out=%0b lane=%0b expected no output", out, lane_sel);
      end
      if (exp_q.size() != 0) check("stream", 16'({lane_sel, out}), 16'(exp_q.pop_front()));
    end
  end

  initial begin
    vectors = 0; miscompares = 0;
    rst_n = 1'b0; in0 = 0; in0_vld = 0; in1 = 0; in1_vld = 0; clr = 0;
    #1;
    check("rst_out",      16'(out),      16'd0);
    check("rst_out_vld",  16'(out_vld),  16'd0);
    check("rst_lane_sel", 16'(lane_sel), 16'd0);
    check("rst_ovf_err",  16'(ovf_err),  16'd0);
    check("rst_bit_cnt",  16'(bit_cnt),  16'd0);
    @(negedge clk); rst_n = 1'b1;

    // 1: ordered stream, lanes alternate at half rate each
    exp_q.push_back(2'b01); tick(1, 1, 0, 0, 0);
    check("t1_no_bypass", 16'(out_vld), 16'd0);
    exp_q.push_back(2'b11); tick(0, 0, 1, 1, 0);
    check("t1_first_out", 16'(out_vld), 16'd1);
    exp_q.push_back(2'b00); tick(1, 0, 0, 0, 0);
    exp_q.push_back(2'b11); tick(0, 0, 1, 1, 0);
    tick(0, 0, 0, 0, 0);
    check("t1_sustained", 16'(out_vld), 16'd1);
    tick(0, 0, 0, 0, 0);
    check("t1_idle", 16'(out_vld), 16'd0);
    check("t1_bit_cnt", 16'(bit_cnt), 16'd4);

    // 2: lane1 leads by three bits; nothing leaves until lane0 arrives
    tick(0, 0, 0, 0, 1);
    check("t2_clr_cnt", 16'(bit_cnt), 16'd0);
    tick(0, 0, 1, 1, 0);
    tick(0, 0, 1, 0, 0);
    tick(0, 0, 1, 1, 0);
    check("t2_wait_lane0", 16'(out_vld), 16'd0);
    exp_q.push_back(2'b00); exp_q.push_back(2'b11);
    tick(1, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0);
    check("t2_bit_cnt", 16'(bit_cnt), 16'd2);
    // lane1 still holds 0,1; one more lane0 bit releases the queued 0
    exp_q.push_back(2'b01); exp_q.push_back(2'b10);
    tick(1, 1, 0, 0, 0);
    tick(0, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0);
    check("t2_lane1_queued", 16'(bit_cnt), 16'd4);

    // 3: overflow lane1 with lane0 idle
    tick(0, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) tick(0, 0, 1, 1, 0);
    check("t3_no_ovf_at_depth", 16'(ovf_err), 16'd0);
    tick(0, 0, 1, 0, 0);
    check("t3_ovf_set", 16'(ovf_err), 16'd1);
    check("t3_no_out", 16'(out_vld), 16'd0);
    tick(1, 1, 1, 1, 0);
    tick(0, 0, 0, 0, 0);
    check("t3_err_frozen", 16'(out_vld), 16'd0);
    check("t3_ovf_held", 16'(ovf_err), 16'd1);

    // 4: clr with a lane0 bit in the same cycle; that bit must be dropped
    tick(1, 1, 0, 0, 1);
    check("t4_ovf_clr", 16'(ovf_err), 16'd0);
    check("t4_cnt_clr", 16'(bit_cnt), 16'd0);
    exp_q.push_back(2'b01); tick(1, 1, 0, 0, 0);
    exp_q.push_back(2'b10); tick(0, 0, 1, 0, 0);
    tick(0, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0);
    check("t4_bit_cnt", 16'(bit_cnt), 16'd2);

    // 5: 17 bits through a 4-bit counter; FIFO pointers wrap several times
    tick(0, 0, 0, 0, 1);
    for (int i = 0; i < 17; i++) begin
      logic [4:0] iv;
      logic       b;
      iv = 5'(i);
      b  = iv[0] ^ iv[1];
      exp_q.push_back({iv[0], b});
      if (iv[0]) tick(0, 0, 1, b, 0);
      else       tick(1, b, 0, 0, 0);
    end
    tick(0, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0);
    check("t5_cnt_wrap", 16'(bit_cnt), 16'd1);
    check("t5_all_delivered", 16'(exp_q.size()), 16'd0);

    // 6: async reset mid-stream; lane1 bit just delivered, two lane0 bits pending
    exp_q.push_back(2'b11); tick(1, 1, 1, 1, 0);
    tick(1, 1, 0, 0, 0);
    check("t6_pre_rst_vld", 16'(out_vld), 16'd1);
    #2;
    rst_n = 1'b0; in0_vld = 0; in1_vld = 0; in0 = 0; in1 = 0;
    #1;
    check("t6_rst_out",     16'(out),      16'd0);
    check("t6_rst_out_vld", 16'(out_vld),  16'd0);
    check("t6_rst_lane",    16'(lane_sel), 16'd0);
    check("t6_rst_cnt",     16'(bit_cnt),  16'd0);
    @(negedge clk); rst_n = 1'b1;
    exp_q.push_back(2'b00); tick(1, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0);
    check("t6_first_after_rst", 16'({out_vld, lane_sel, out}), 16'b100);
    tick(0, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0);
    check("t6_bit_cnt", 16'(bit_cnt), 16'd1);
    check("end_queue_empty", 16'(exp_q.size()), 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
